// File: rtl/pixel_frame_sequencer_if.sv
// Readout bus between pixel_frame_sequencer and the downstream consumer.
//   READ_ADDR  : output group select (driven by the sequencer)
//   DATA_VALID : the READ_ADDR group is on the bus (driven by the sequencer)
//   OUT_READY  : consumer accepts the current beat (driven by the consumer)
// A beat transfers on a rising clock edge where DATA_VALID & OUT_READY.
interface pixel_frame_sequencer_if #(
  parameter int unsigned ADDR_W = 2
) ();

  logic [ADDR_W-1:0] READ_ADDR;
  logic              DATA_VALID;
  logic              OUT_READY;

  modport master (
    output READ_ADDR,
    output DATA_VALID,
    input  OUT_READY
  );

  modport slave (
    input  READ_ADDR,
    input  DATA_VALID,
    output OUT_READY
  );

endinterface

// File: rtl/pixel_frame_sequencer.sv
// Frame controller for the digital pixel sensor array. Runs the
// erase -> expose -> convert -> read phase sequence, drives the shared ADC
// counter during conversion and steps the output group address during readout.
//
// Ports:
//   SYSTEM_CLK     : clock, all logic on the rising edge
//   RESET          : synchronous active-high reset, aborts any frame
//   START          : begin a frame, only honoured in idle
//   CONTINUOUS     : sampled when the last beat is accepted; 1 restarts at erase
//   EXPOSE_CYCLES  : exposure length, latched at frame start (0 behaves as 1)
//   rd_bus         : readout bus (READ_ADDR, DATA_VALID out; OUT_READY in)
//   ERASE          : pixel memory erase strobe
//   EXPOSE         : photodiode integration enable
//   CONVERT        : ramp/counter enable
//   COUNTER_RESET  : one-cycle counter clear on the first conversion cycle
//   COUNTER_VALUE  : conversion code presented to the pixel memories
//   WRITE_ENABLE   : pixel memories track COUNTER_VALUE
//   BUSY           : high in every state except idle
//   FRAME_DONE     : one-cycle pulse the cycle after the last beat is accepted
//
// All outputs are registered; they are set on the edge that enters the state
// they belong to, so they line up exactly with the state they decode.
module pixel_frame_sequencer #(
  parameter int unsigned WIDTH                  = 3,
  parameter int unsigned HEIGHT                 = 3,
  parameter int unsigned OUTPUT_BUS_PIXEL_WIDTH = 3,
  parameter int unsigned BIT_DEPTH              = 10,
  parameter int unsigned ERASE_CYCLES           = 4,
  parameter int unsigned EXP_W                  = 16
) (
  input  logic                 SYSTEM_CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic                 CONTINUOUS,
  input  logic [EXP_W-1:0]     EXPOSE_CYCLES,
  pixel_frame_sequencer_if.master rd_bus,
  output logic                 ERASE,
  output logic                 EXPOSE,
  output logic                 CONVERT,
  output logic                 COUNTER_RESET,
  output logic [BIT_DEPTH-1:0] COUNTER_VALUE,
  output logic                 WRITE_ENABLE,
  output logic                 BUSY,
  output logic                 FRAME_DONE
);

  localparam int unsigned NUM_GROUPS = (WIDTH * HEIGHT) / OUTPUT_BUS_PIXEL_WIDTH;
  localparam int unsigned ADDR_W     = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int unsigned ERASE_W    = $clog2(ERASE_CYCLES + 1);
  // One down-counter serves both the erase and the exposure phase.
  localparam int unsigned CNT_W      = (EXP_W > ERASE_W) ? EXP_W : ERASE_W;

  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(NUM_GROUPS - 1);
  localparam logic [CNT_W-1:0]  EraseLoad = CNT_W'(ERASE_CYCLES - 1);

  if ((WIDTH * HEIGHT) % OUTPUT_BUS_PIXEL_WIDTH != 0) begin : g_bad_geometry
    $error("WIDTH*HEIGHT must be a multiple of OUTPUT_BUS_PIXEL_WIDTH");
  end
  if (ERASE_CYCLES < 1) begin : g_bad_erase
    $error("ERASE_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    StIdle,
    StErase,
    StExpose,
    StConvert,
    StRead
  } state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [EXP_W-1:0]     exp_q;
  logic                 erase_q;
  logic                 expose_q;
  logic                 convert_q;
  logic                 cnt_rst_q;
  logic [BIT_DEPTH-1:0] cval_q;
  logic                 we_q;
  logic [ADDR_W-1:0]    addr_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 done_q;

  // Zero exposure would skip the phase entirely; clamp it to one clock.
  logic [EXP_W-1:0] exp_eff;
  assign exp_eff = (EXPOSE_CYCLES == '0) ? EXP_W'(1) : EXPOSE_CYCLES;

  logic beat;
  assign beat = valid_q & rd_bus.OUT_READY;

  always_ff @(posedge SYSTEM_CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      exp_q     <= '0;
      erase_q   <= 1'b0;
      expose_q  <= 1'b0;
      convert_q <= 1'b0;
      cnt_rst_q <= 1'b0;
      cval_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cnt_rst_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (START) begin
            state_q <= StErase;
            exp_q   <= exp_eff;
            cnt_q   <= EraseLoad;
            erase_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        StErase: begin
          if (cnt_q == '0) begin
            state_q  <= StExpose;
            erase_q  <= 1'b0;
            expose_q <= 1'b1;
            cnt_q    <= CNT_W'(exp_q - 1'b1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        StExpose: begin
          if (cnt_q == '0) begin
            state_q   <= StConvert;
            expose_q  <= 1'b0;
            convert_q <= 1'b1;
            we_q      <= 1'b1;
            cnt_rst_q <= 1'b1;
            cval_q    <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        StConvert: begin
          // Leave on the max code so the counter never presents a wrap;
          // the code then holds until the next conversion clears it.
          if (cval_q == '1) begin
            state_q   <= StRead;
            convert_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            valid_q   <= 1'b1;
          end else begin
            cval_q <= cval_q + 1'b1;
          end
        end

        StRead: begin
          if (beat) begin
            if (addr_q == LastAddr) begin
              done_q  <= 1'b1;
              valid_q <= 1'b0;
              addr_q  <= '0;
              if (CONTINUOUS) begin
                state_q <= StErase;
                exp_q   <= exp_eff;
                cnt_q   <= EraseLoad;
                erase_q <= 1'b1;
              end else begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign ERASE             = erase_q;
  assign EXPOSE            = expose_q;
  assign CONVERT           = convert_q;
  assign COUNTER_RESET     = cnt_rst_q;
  assign COUNTER_VALUE     = cval_q;
  assign WRITE_ENABLE      = we_q;
  assign BUSY              = busy_q;
  assign FRAME_DONE        = done_q;
  assign rd_bus.READ_ADDR  = addr_q;
  assign rd_bus.DATA_VALID = valid_q;

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Scoreboard bench for pixel_frame_sequencer. The stimulus side turns each
// frame into its expected per-cycle output trace (phase lengths and the
// readout ready pattern) and queues it; a monitor pops one entry whenever the
// DUT shows BUSY or FRAME_DONE and compares.
module tb_pixel_frame_sequencer;

  localparam int unsigned Width      = 3;
  localparam int unsigned Height     = 3;
  localparam int unsigned BusPix     = 3;
  localparam int unsigned BitDepth   = 4;
  localparam int unsigned EraseCyc   = 4;
  localparam int unsigned ExpW       = 16;
  localparam int unsigned NumGroups  = Width * Height / BusPix;
  localparam int unsigned AddrW      = (NumGroups > 1) ? $clog2(NumGroups) : 1;
  localparam int unsigned ConvLen    = 1 << BitDepth;

  typedef struct packed {
    logic                erase;
    logic                expose;
    logic                convert;
    logic                cnt_rst;
    logic [BitDepth-1:0] cval;
    logic                we;
    logic [AddrW-1:0]    addr;
    logic                valid;
    logic                busy;
    logic                done;
  } obs_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                cont;
  logic [ExpW-1:0]     exp_cycles;
  logic                erase, expose, convert, cnt_rst, we, busy, done;
  logic [BitDepth-1:0] cval;
  obs_t                got;

  pixel_frame_sequencer_if #(.ADDR_W(AddrW)) bus ();

  pixel_frame_sequencer #(
    .WIDTH                 (Width),
    .HEIGHT                (Height),
    .OUTPUT_BUS_PIXEL_WIDTH(BusPix),
    .BIT_DEPTH             (BitDepth),
    .ERASE_CYCLES          (EraseCyc),
    .EXP_W                 (ExpW)
  ) dut (
    .SYSTEM_CLK   (clk),
    .RESET        (rst),
    .START        (start),
    .CONTINUOUS   (cont),
    .EXPOSE_CYCLES(exp_cycles),
    .rd_bus       (bus),
    .ERASE        (erase),
    .EXPOSE       (expose),
    .CONVERT      (convert),
    .COUNTER_RESET(cnt_rst),
    .COUNTER_VALUE(cval),
    .WRITE_ENABLE (we),
    .BUSY         (busy),
    .FRAME_DONE   (done)
  );

  always #5 clk = ~clk;

  assign got = {erase, expose, convert, cnt_rst, cval, we, bus.READ_ADDR, bus.DATA_VALID,
                busy, done};

  obs_t        sb[$];     // expected trace, one entry per busy/done cycle
  obs_t        trace[$];  // scratch for one frame
  bit          rdy_q[$];  // OUT_READY for successive readout cycles
  bit          pat[$];    // optional fixed ready pattern for the next frame
  int          total = 0;
  int          bad = 0;
  bit          mon_en = 0;
  bit          pend_done = 0;
  int unsigned m_cval = 0;

  function automatic string fmt(input obs_t o);
    return $sformatf("er=%0b ex=%0b cv=%0b cr=%0b val=%0d we=%0b addr=%0d dv=%0b busy=%0b done=%0b",
                     o.erase, o.expose, o.convert, o.cnt_rst, o.cval, o.we, o.addr, o.valid,
                     o.busy, o.done);
  endfunction

  // Expected trace of one frame from the phase rules. Returns its length in
  // cycles; only the first 'keep' entries are queued (0 = all).
  function automatic int gen_frame(input int unsigned exp_in, input bit cont_after,
                                   input int unsigned keep, input int unsigned stall_pct);
    obs_t        o;
    int unsigned e;
    int unsigned addr;
    bit          r;
    e    = (exp_in == 0) ? 1 : exp_in;
    addr = 0;
    trace.delete();
    for (int i = 0; i < int'(EraseCyc); i++) begin
      o = '0; o.erase = 1'b1; o.busy = 1'b1; o.cval = BitDepth'(m_cval);
      trace.push_back(o);
    end
    for (int i = 0; i < int'(e); i++) begin
      o = '0; o.expose = 1'b1; o.busy = 1'b1; o.cval = BitDepth'(m_cval);
      trace.push_back(o);
    end
    for (int v = 0; v < int'(ConvLen); v++) begin
      o = '0; o.convert = 1'b1; o.we = 1'b1; o.cnt_rst = (v == 0); o.busy = 1'b1;
      o.cval = BitDepth'(v);
      trace.push_back(o);
    end
    m_cval = ConvLen - 1;
    while (addr < NumGroups) begin
      if (pat.size() > 0) r = pat.pop_front();
      else r = ($urandom_range(0, 99) >= stall_pct);
      rdy_q.push_back(r);
      o = '0; o.valid = 1'b1; o.busy = 1'b1; o.addr = AddrW'(addr); o.cval = BitDepth'(m_cval);
      trace.push_back(o);
      if (r) addr++;
    end
    if (pend_done) trace[0].done = 1'b1;
    pend_done = cont_after;
    if (!cont_after) begin
      o = '0; o.done = 1'b1; o.cval = BitDepth'(m_cval);
      trace.push_back(o);
    end
    for (int i = 0; i < trace.size() && (keep == 0 || i < int'(keep)); i++) sb.push_back(trace[i]);
    return trace.size();
  endfunction

  // Present the queued ready value while a beat is offered.
  initial bus.OUT_READY = 1'b0;
  always @(posedge clk) begin
    #1;
    if (bus.DATA_VALID === 1'b1 && rdy_q.size() > 0) bus.OUT_READY = rdy_q.pop_front();
    else bus.OUT_READY = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin : monitor
    obs_t w;
    if (mon_en && (got.busy === 1'b1 || got.done === 1'b1)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        if (bad < 20) $display("FAIL trace_extra got {%s} want {idle}", fmt(got));
      end else begin
        w = sb.pop_front();
        if (got !== w) begin
          bad++;
          if (bad < 20) $display("FAIL trace got {%s} want {%s}", fmt(got), fmt(w));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    obs_t w;
    w = '0;
    w.cval = BitDepth'(m_cval);
    total++;
    if (got !== w) begin
      bad++;
      $display("FAIL %s got {%s} want {%s}", name, fmt(got), fmt(w));
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 2000 && sb.size() > 0; i++) cyc(1);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain got %0d pending want 0", name, sb.size());
      sb.delete();
    end
    check_idle({name, "_idle"});
  endtask

  task automatic model_reset();
    rdy_q.delete();
    pat.delete();
    m_cval    = 0;
    pend_done = 0;
  endtask

  // n back-to-back frames (continuous when n>1) with exposures e0..e2.
  // Each later exposure is set during the preceding frame, after its latch.
  task automatic run_chain(input int n, input int unsigned e0, input int unsigned e1,
                           input int unsigned e2, input int unsigned stall_pct,
                           input string name);
    int unsigned ev[3];
    int          lens[3];
    int          pos;
    int          acc;
    ev[0] = e0; ev[1] = e1; ev[2] = e2;
    for (int f = 0; f < n; f++) lens[f] = gen_frame(ev[f], f < n - 1, 0, stall_pct);
    cont       = (n > 1);
    exp_cycles = ExpW'(ev[0]);
    start      = 1'b1;
    cyc(1);
    start = 1'b0;
    if (n > 1) exp_cycles = ExpW'(ev[1]);
    else exp_cycles = ExpW'($urandom_range(0, 20));
    pos = 1;
    acc = 0;
    for (int f = 1; f < n; f++) begin
      acc += lens[f-1];
      cyc(acc + 1 - pos);
      pos = acc + 1;
      if (f < n - 1) exp_cycles = ExpW'(ev[f+1]);
      else begin
        cont       = 1'b0;
        exp_cycles = ExpW'($urandom_range(0, 20));
      end
    end
    wait_drain(name);
  endtask

  initial begin : stim
    int la;
    rst        = 1'b1;
    start      = 1'b0;
    cont       = 1'b0;
    exp_cycles = ExpW'(10);
    cyc(3);
    model_reset();
    check_idle("reset_state");
    rst    = 1'b0;
    mon_en = 1'b1;
    cyc(2);

    // Basic single-shot frame with the bus always ready.
    run_chain(1, 10, 0, 0, 0, "basic");

    // Five stalled cycles at address 1.
    pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    run_chain(1, 10, 0, 0, 0, "backpressure");

    // Two continuous frames; exposure changed to 3 during frame 1.
    run_chain(2, 10, 3, 0, 0, "continuous");

    // Zero exposure behaves as one clock.
    run_chain(1, 0, 0, 0, 0, "exp_zero");

    // START held across a whole frame: ignored while busy, restarts from idle.
    exp_cycles = ExpW'(5);
    la = gen_frame(5, 0, 0, 20);
    void'(gen_frame(5, 0, 0, 20));
    start = 1'b1;
    cyc(la + 1);
    start = 1'b0;
    wait_drain("start_held");

    // Reset while the counter shows 7.
    exp_cycles = ExpW'(6);
    void'(gen_frame(6, 0, EraseCyc + 6 + 8, 0));
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(EraseCyc + 6 + 7);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    model_reset();
    check_idle("abort_outputs");
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL abort_trace got %0d pending want 0", sb.size());
      sb.delete();
    end
    cyc(1);
    check_idle("abort_no_done");
    run_chain(1, 7, 0, 0, 0, "after_abort");

    // RESET and START together in idle.
    rst   = 1'b1;
    start = 1'b1;
    cyc(1);
    model_reset();
    check_idle("rst_start");
    rst   = 1'b0;
    start = 1'b0;
    cyc(1);
    check_idle("rst_start_after");

    // Randomized frames, chains and backpressure.
    for (int it = 0; it < 8; it++) begin
      run_chain($urandom_range(1, 3), $urandom_range(0, 12), $urandom_range(0, 12),
                $urandom_range(0, 12), 30, "random");
      cyc($urandom_range(1, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
